// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and decode-side handshake bundle for the IF/ID register
interface decode_stage_if #(
  parameter int XLEN = 64
);
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            if_ready;
  logic            flush;

  logic            id_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_imm;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_branch;
  logic            id_jump;
  logic            id_alu_src;
  logic            id_illegal;

  modport master (
    output if_valid, if_pc, if_instr, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_instr, id_opcode, id_funct3, id_funct7,
           id_rs1, id_rs2, id_rd, id_imm, id_reg_write, id_mem_read, id_mem_write,
           id_branch, id_jump, id_alu_src, id_illegal
  );

  modport slave (
    input  if_valid, if_pc, if_instr, flush, id_ready,
    output if_ready, id_valid, id_pc, id_instr, id_opcode, id_funct3, id_funct7,
           id_rs1, id_rs2, id_rd, id_imm, id_reg_write, id_mem_read, id_mem_write,
           id_branch, id_jump, id_alu_src, id_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - one-entry IF/ID register with registered RV64 decode
// Optional macro DECODE_ILLEGAL_CHECK_EN flags unsupported opcodes on id_illegal.
module decode_stage #(
  parameter int          XLEN      = 64,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_src;
    logic            illegal;
  } payload_t;

  function automatic payload_t decode(input logic [XLEN-1:0] pc, input logic [31:0] instr);
    payload_t    p;
    fmt_t        fmt;
    logic [31:0] imm32;
    p        = '0;
    fmt      = FMT_X;
    imm32    = '0;
    p.pc     = pc;
    p.instr  = instr;
    p.opcode = instr[6:0];
    p.funct3 = instr[14:12];
    p.funct7 = instr[31:25];
    p.rs1    = instr[19:15];
    p.rs2    = instr[24:20];

    case (instr[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: fmt = FMT_I;
      7'h23:                      fmt = FMT_S;
      7'h63:                      fmt = FMT_B;
      7'h37, 7'h17:               fmt = FMT_U;
      7'h6F:                      fmt = FMT_J;
      7'h33, 7'h3B:               fmt = FMT_R;
      default:                    fmt = FMT_X;
    endcase

    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'h000};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    p.imm = XLEN'($signed(imm32));

    // Stores and branches have no destination; bits 11:7 carry immediate bits there.
    p.rd        = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : instr[11:7];
    p.reg_write = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
    p.alu_src   = (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_U) || (fmt == FMT_J);
    p.mem_read  = (instr[6:0] == 7'h03);
    p.mem_write = (instr[6:0] == 7'h23);
    p.branch    = (instr[6:0] == 7'h63);
    p.jump      = (instr[6:0] == 7'h6F) || (instr[6:0] == 7'h67);
`ifdef DECODE_ILLEGAL_CHECK_EN
    p.illegal   = (fmt == FMT_X);
`else
    p.illegal   = 1'b0;
`endif
    return p;
  endfunction

  payload_t q_r;
  payload_t empty_p;
  payload_t in_p;
  logic     valid_r;
  logic     accept;

  always_comb begin
    empty_p         = decode('0, NOP_INSTR);
    empty_p.illegal = 1'b0;
  end

  always_comb begin
    in_p = decode(bus.if_pc, bus.if_instr);
  end

  assign bus.if_ready = !valid_r || bus.id_ready;
  assign accept       = bus.if_valid && bus.if_ready;

  // Reset beats flush beats accept; a drained register reloads the NOP decode.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_r <= 1'b0;
      q_r     <= empty_p;
    end else if (accept) begin
      valid_r <= 1'b1;
      q_r     <= in_p;
    end else if (bus.id_ready) begin
      valid_r <= 1'b0;
      q_r     <= empty_p;
    end
  end

  assign bus.id_valid     = valid_r;
  assign bus.id_pc        = q_r.pc;
  assign bus.id_instr     = q_r.instr;
  assign bus.id_opcode    = q_r.opcode;
  assign bus.id_funct3    = q_r.funct3;
  assign bus.id_funct7    = q_r.funct7;
  assign bus.id_rs1       = q_r.rs1;
  assign bus.id_rs2       = q_r.rs2;
  assign bus.id_rd        = q_r.rd;
  assign bus.id_imm       = q_r.imm;
  assign bus.id_reg_write = q_r.reg_write;
  assign bus.id_mem_read  = q_r.mem_read;
  assign bus.id_mem_write = q_r.mem_write;
  assign bus.id_branch    = q_r.branch;
  assign bus.id_jump      = q_r.jump;
  assign bus.id_alu_src   = q_r.alu_src;
  assign bus.id_illegal   = q_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with directed and random stimulus
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(64)) bus ();

  decode_stage #(.XLEN(64), .NOP_INSTR(32'h00000013)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, jp, as, ill;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  bit   go = 1'b0;
  exp_t q[$];
  exp_t empty_exp;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: classify by opcode, then take the signed value of the format's immediate.
  function automatic exp_t ref_decode(input logic [63:0] pc, input logic [31:0] ins);
    exp_t               e;
    byte                fmt;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [31:0] u32;
    logic signed [20:0] j21;
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    u32 = {ins[31:12], 12'h000};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (ins[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: fmt = "I";
      7'h23:        fmt = "S";
      7'h63:        fmt = "B";
      7'h37, 7'h17: fmt = "U";
      7'h6F:        fmt = "J";
      7'h33, 7'h3B: fmt = "R";
      default:      fmt = "X";
    endcase
    e.pc    = pc;
    e.instr = ins;
    case (fmt)
      "I":     e.imm = 64'(i12);
      "S":     e.imm = 64'(s12);
      "B":     e.imm = 64'(b13);
      "U":     e.imm = 64'(u32);
      "J":     e.imm = 64'(j21);
      default: e.imm = 64'd0;
    endcase
    e.rd  = (fmt == "S" || fmt == "B") ? 5'd0 : ins[11:7];
    e.rw  = (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J");
    e.as  = (fmt == "I" || fmt == "S" || fmt == "U" || fmt == "J");
    e.mr  = (ins[6:0] == 7'h03);
    e.mw  = (ins[6:0] == 7'h23);
    e.br  = (ins[6:0] == 7'h63);
    e.jp  = (ins[6:0] == 7'h6F || ins[6:0] == 7'h67);
    e.ill = ILL_EN && (fmt == "X");
    return e;
  endfunction

  task automatic cmp_payload(input exp_t e);
    logic [31:0] w;
    w = e.instr;
    chk("id_pc",        bus.id_pc,                e.pc);
    chk("id_instr",     64'(bus.id_instr),        64'(w));
    chk("id_opcode",    64'(bus.id_opcode),       64'(w[6:0]));
    chk("id_funct3",    64'(bus.id_funct3),       64'(w[14:12]));
    chk("id_funct7",    64'(bus.id_funct7),       64'(w[31:25]));
    chk("id_rs1",       64'(bus.id_rs1),          64'(w[19:15]));
    chk("id_rs2",       64'(bus.id_rs2),          64'(w[24:20]));
    chk("id_rd",        64'(bus.id_rd),           64'(e.rd));
    chk("id_imm",       bus.id_imm,               e.imm);
    chk("id_reg_write", 64'(bus.id_reg_write),    64'(e.rw));
    chk("id_mem_read",  64'(bus.id_mem_read),     64'(e.mr));
    chk("id_mem_write", 64'(bus.id_mem_write),    64'(e.mw));
    chk("id_branch",    64'(bus.id_branch),       64'(e.br));
    chk("id_jump",      64'(bus.id_jump),         64'(e.jp));
    chk("id_alu_src",   64'(bus.id_alu_src),      64'(e.as));
    chk("id_illegal",   64'(bus.id_illegal),      64'(e.ill));
  endtask

  // Monitor: every cycle compare the presented payload with the scoreboard head.
  initial begin
    wait (go);
    forever begin
      @(negedge clk);
      #2;
      chk("id_valid", 64'(bus.id_valid), 64'(q.size() != 0));
      chk("if_ready", 64'(bus.if_ready), 64'((q.size() == 0) || bus.id_ready));
      if (q.size() != 0) cmp_payload(q[0]);
      else               cmp_payload(empty_exp);
      if (q.size() != 0 && bus.id_ready) void'(q.pop_front());
    end
  end

  task automatic cyc(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                     input logic fl, input logic rdy, input logic r);
    bit had;
    bit acc;
    @(negedge clk);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_instr = ins;
    bus.flush    = fl;
    bus.id_ready = rdy;
    rst          = r;
    had = (q.size() != 0);
    acc = v && (!had || rdy);
    #3;
    if (r || fl)  q.delete();
    else if (acc) q.push_back(ref_decode(pc, ins));
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [6:0]  ops [12];
  logic [31:0] w;
  logic [31:0] ins;
  logic [63:0] pc;
  int          idx;

  initial begin
    empty_exp     = ref_decode(64'd0, 32'h00000013);
    empty_exp.ill = 1'b0;
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h00};
    bus.if_valid = 1'b0;
    bus.if_pc    = '0;
    bus.if_instr = '0;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b0;

    cyc(1'b0, 64'd0, 32'h0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 64'h100, 32'h00108093, 1'b0, 1'b1, 1'b1);
    go = 1'b1;
    after_edge();
    chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
    chk("rst_id_pc", bus.id_pc, 64'd0);
    chk("rst_id_instr", 64'(bus.id_instr), 64'h13);
    chk("rst_id_illegal", 64'(bus.id_illegal), 64'd0);

    cyc(1'b1, 64'd4, 32'h00108093, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("addi_valid", 64'(bus.id_valid), 64'd1);
    chk("addi_rs1", 64'(bus.id_rs1), 64'd1);
    chk("addi_rd", 64'(bus.id_rd), 64'd1);
    chk("addi_imm", bus.id_imm, 64'd1);
    chk("addi_opcode", 64'(bus.id_opcode), 64'h13);
    chk("addi_reg_write", 64'(bus.id_reg_write), 64'd1);
    chk("addi_alu_src", 64'(bus.id_alu_src), 64'd1);

    cyc(1'b1, 64'h28, 32'hFE000EE3, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("beq_imm", bus.id_imm, 64'hFFFFFFFFFFFFFFFC);
    chk("beq_branch", 64'(bus.id_branch), 64'd1);
    chk("beq_rd", 64'(bus.id_rd), 64'd0);
    chk("beq_reg_write", 64'(bus.id_reg_write), 64'd0);

    cyc(1'b1, 64'h30, 32'h123452B7, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("lui_imm", bus.id_imm, 64'h0000000012345000);
    chk("lui_rd", 64'(bus.id_rd), 64'd5);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 64'h34, 32'h00500113, 1'b0, 1'b0, 1'b0);
      after_edge();
      chk("stall_if_ready", 64'(bus.if_ready), 64'd0);
      chk("stall_imm", bus.id_imm, 64'h0000000012345000);
      chk("stall_pc", bus.id_pc, 64'h30);
    end
    cyc(1'b1, 64'h34, 32'h00500113, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("release_pc", bus.id_pc, 64'h34);
    chk("release_instr", 64'(bus.id_instr), 64'h00500113);

    cyc(1'b1, 64'h38, 32'h00208113, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("flush_valid", 64'(bus.id_valid), 64'd0);
    chk("flush_instr", 64'(bus.id_instr), 64'h13);
    chk("flush_pc", bus.id_pc, 64'd0);
    cyc(1'b1, 64'h3C, 32'h00C58593, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("post_flush_valid", 64'(bus.id_valid), 64'd1);
    chk("post_flush_pc", bus.id_pc, 64'h3C);

    cyc(1'b1, 64'h40, 32'h0000007F, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("ill_flag", 64'(bus.id_illegal), 64'(ILL_EN));
    chk("ill_ctrl", 64'({bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
                         bus.id_branch, bus.id_jump, bus.id_alu_src}), 64'd0);
    chk("ill_imm", bus.id_imm, 64'd0);

    cyc(1'b1, 64'h44, 32'h00108093, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h48, 32'h00208113, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h4C, 32'h00308193, 1'b0, 1'b0, 1'b1);
    after_edge();
    chk("rst_stall_valid", 64'(bus.id_valid), 64'd0);
    chk("rst_stall_pc", bus.id_pc, 64'd0);
    cyc(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_release_if_ready", 64'(bus.if_ready), 64'd1);

    for (int n = 0; n < 3000; n++) begin
      w   = $urandom();
      idx = $urandom_range(0, 11);
      ins = {w[31:7], (idx == 11) ? 7'($urandom()) : ops[idx]};
      pc  = {32'($urandom()), 32'($urandom())} & ~64'd3;
      cyc(($urandom() % 4) != 0, pc, ins, ($urandom() % 16) == 0,
          ($urandom() % 3) != 0, ($urandom() % 128) == 0);
    end
    for (int n = 0; n < 4; n++) cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 64: width of PC and immediate datapath.
REQ-002 Parameter NOP_INSTR, default 32'h00000013: instruction word reported in the payload while the register is empty.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_valid  input  1  fetch presents a valid instruction this cycle.
REQ-006 if_pc  input  XLEN  PC of presented instruction.
REQ-007 if_instr  input  32  presented instruction word.
REQ-008 if_ready  output  1  decode accepts the presented instruction this cycle.
REQ-009 flush  input  1  kill held and incoming instruction (taken branch resolved downstream).
REQ-010 id_ready  input  1  downstream accepts id_* this cycle.
REQ-011 id_valid  output  1  id_* payload valid.
REQ-012 id_pc  output  XLEN  PC of decoded instruction.
REQ-013 id_instr  output  32  raw instruction word.
REQ-014 id_opcode / id_funct3 / id_funct7  output  7/3/7  instruction fields.
REQ-015 id_rs1 / id_rs2 / id_rd  output  5 each  register indices.
REQ-016 id_imm  output  XLEN  sign-extended immediate.
REQ-017 id_reg_write / id_mem_read / id_mem_write / id_branch / id_jump / id_alu_src  output  1 each  control.
REQ-018 id_illegal  output  1  unsupported opcode flag.

Function
REQ-019 Block SHALL be a one-entry IF/ID register with valid/ready handshake; transfer occurs when if_valid && if_ready.
REQ-020 if_ready SHALL equal !id_valid || id_ready (combinational; full throughput, no bubble under continuous ready).
REQ-021 Latency SHALL be exactly 1 cycle: an accepted instruction appears on id_* with id_valid=1 on the next rising edge.
REQ-022 While id_valid && !id_ready, all id_* outputs SHALL hold stable and no new instruction is accepted.
REQ-023 When id_valid && id_ready && no new accept, id_valid SHALL drop to 0 next cycle.
REQ-024 flush SHALL take priority over accept: next cycle id_valid=0 and the instruction presented in the flush cycle is dropped; if_ready is unaffected by flush.
REQ-025 Decoded fields and controls SHALL be registered alongside the instruction, not computed from the held word after the edge.
REQ-026 Immediates per opcode: I (0x03,0x13,0x1B,0x67), S (0x23), B (0x63, bit0=0), U (0x37,0x17, low 12 bits zero), J (0x6F, bit0=0); all sign-extended from instr[31] to XLEN; R-type (0x33,0x3B) imm=0.
REQ-027 Controls: reg_write for R/I/U/J/load; mem_read for 0x03; mem_write for 0x23; branch for 0x63; jump for 0x6F/0x67; alu_src for all I/S/U/J types.
REQ-028 Empty register (id_valid=0) SHALL present the NOP_INSTR decoding on payload outputs.
REQ-029 id_rd SHALL be forced to 0 for S and B types.

Reset
REQ-030 With rst=1 at a rising edge: id_valid=0, id_pc=0, id_instr=NOP_INSTR, fields/controls those of NOP_INSTR, id_illegal=0.
REQ-031 rst SHALL dominate flush and accept; an instruction presented during reset is dropped.
REQ-032 if_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-033 Macro DECODE_ILLEGAL_CHECK_EN: when defined, any opcode outside REQ-026 sets id_illegal=1 and forces all id_* control outputs to 0 for that instruction.
REQ-034 Without DECODE_ILLEGAL_CHECK_EN, id_illegal SHALL be tied 0 and unknown opcodes decode with imm=0 and controls 0.

Verification
REQ-035 Reset, then if_valid=1, if_pc=4, if_instr=0x00108093, id_ready=1 -> next cycle id_valid=1, id_rs1=1, id_rd=1, id_imm=1, id_opcode=0x13, id_reg_write=1, id_alu_src=1.
REQ-036 Accept 0xFE000EE3 (BEQ x0,x0,-4) at pc 0x28 -> id_imm=0xFFFFFFFFFFFFFFFC, id_branch=1, id_rd=0, id_reg_write=0.
REQ-037 Accept 0x123452B7 (LUI x5) with id_ready=0 for 3 cycles -> id_imm=0x0000000012345000, id_rd=5, outputs stable, if_ready=0 throughout; on release next instruction accepted same cycle.
REQ-038 id_valid=1, flush=1 with if_valid=1 -> next cycle id_valid=0, payload equals NOP_INSTR decode; no instruction lost when flush=0 in the following cycle.
REQ-039 With DECODE_ILLEGAL_CHECK_EN, accept 0x0000007F -> id_illegal=1, all controls 0; without macro -> id_illegal=0.
REQ-040 Assert rst mid-stall with id_valid=1 -> next cycle id_valid=0, id_pc=0, if_ready=1 after release.
